cache_p_control: RTL

- Control FSM for the 4-way pipelined cache datapath. It consumes hit, dirty and request status from the datapath's IF/ID request register.
- It drives the datapath's way-load, LRU-load, address-select, access-select and stall controls, and runs the physical-memory handshake through the cache adapter.
- On a hit it responds to the CPU in the compare cycle. On a miss it writes back the dirty victim, refills the line, then replays the compare.

---
 rtl/cache_p_control.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cache_p_control.sv
// Cache control FSM: 0-cycle hits in COMPARE; misses stall through WRITEBACK/FILL/REPLAY and wait on pmem_resp.
// Outputs are combinational from state and inputs; optional perf counters under CACHE_P_PERF_EN.
module cache_p_control #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 read_o,
   input  logic                 write_o,
   input  logic                 cache_hit,
   input  logic                 dirty,
   input  logic                 pmem_resp,
   output logic                 load,
   output logic                 load_lru,
   output logic                 address_sel,
   output logic                 access_sel,
   output logic                 stall,
   output logic                 mem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write
`ifdef CACHE_P_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
`endif
);

   typedef enum logic [1:0] {
      S_COMPARE   = 2'd0,
      S_WRITEBACK = 2'd1,
      S_FILL      = 2'd2,
      S_REPLAY    = 2'd3
   } state_e;

   state_e state_q, state_d;
   logic   req;

   assign req = read_o | write_o;

   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_COMPARE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      load        = 1'b0;
      load_lru    = 1'b0;
      address_sel = 1'b0;
      access_sel  = 1'b0;
      stall       = 1'b0;
      mem_resp    = 1'b0;
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
      case (state_q)
         S_COMPARE: begin
            if (req) begin
               if (cache_hit) begin
                  mem_resp = 1'b1;
                  load_lru = 1'b1;
                  load     = write_o;
               end else begin
                  stall   = 1'b1;
                  state_d = dirty ? S_WRITEBACK : S_FILL;
               end
            end
         end
         S_WRITEBACK: begin
            address_sel = 1'b1;
            pmem_write  = 1'b1;
            stall       = 1'b1;
            if (pmem_resp) state_d = S_FILL;
         end
         S_FILL: begin
            access_sel = 1'b1;
            pmem_read  = 1'b1;
            stall      = 1'b1;
            if (pmem_resp) begin
               load    = 1'b1;
               state_d = S_REPLAY;
            end
         end
         S_REPLAY: begin
            stall   = 1'b1;
            state_d = S_COMPARE;
         end
         default: state_d = S_COMPARE;
      endcase
      // Reset must silence the adapter and CPU immediately, not at the next edge.
      if (!rst) begin
         load        = 1'b0;
         load_lru    = 1'b0;
         address_sel = 1'b0;
         access_sel  = 1'b0;
         stall       = 1'b0;
         mem_resp    = 1'b0;
         pmem_read   = 1'b0;
         pmem_write  = 1'b0;
      end
   end

`ifdef CACHE_P_PERF_EN
   logic                 replay_q;
   logic [CNT_WIDTH-1:0] hit_q, miss_q, wb_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         replay_q <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
         wb_q     <= '0;
      end else begin
         // The hit that completes a replayed miss was already counted as a miss.
         replay_q <= (state_q == S_REPLAY);
         if (mem_resp && !replay_q)
            hit_q <= hit_q + CNT_WIDTH'(1);
         if (state_q == S_COMPARE && state_d != S_COMPARE)
            miss_q <= miss_q + CNT_WIDTH'(1);
         if (state_q == S_WRITEBACK && pmem_resp)
            wb_q <= wb_q + CNT_WIDTH'(1);
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
   assign wb_count   = wb_q;
`endif

endmodule
